// File: rtl/traffic_light_fsm_if.sv
`timescale 1ns/1ps
// traffic_light_fsm_if
// Signal bundle between the intersection sequencer and its surroundings:
// tick time base, walk register, side-street sensor, both signal heads,
// the walk lamp and the walk-register clear strobe.
interface traffic_light_fsm_if;
   logic Tick;
   logic WR;
   logic Sensor;
   logic Main_Red;
   logic Main_Yellow;
   logic Main_Green;
   logic Side_Red;
   logic Side_Yellow;
   logic Side_Green;
   logic Walk_Lamp;
   logic WR_Reset;

   // Environment side: drives the time base and requests, observes the lamps.
   modport master (
      output Tick, WR, Sensor,
      input  Main_Red, Main_Yellow, Main_Green,
      input  Side_Red, Side_Yellow, Side_Green,
      input  Walk_Lamp, WR_Reset
   );

   // Controller side.
   modport slave (
      input  Tick, WR, Sensor,
      output Main_Red, Main_Yellow, Main_Green,
      output Side_Red, Side_Yellow, Side_Green,
      output Walk_Lamp, WR_Reset
   );
endinterface

// File: rtl/traffic_light_fsm.sv
`timescale 1ns/1ps
// traffic_light_fsm
// Main sequencing state machine of the intersection controller. Every phase
// is timed by a 4-bit down-counter that advances only on Tick, so phase
// lengths are counted in ticks rather than clocks. Lamps and the walk
// register clear strobe are registered and change on the same edge as the
// state register.
module traffic_light_fsm #(
   parameter int T_BASE = 6,  // base green, ticks (1..15)
   parameter int T_EXT  = 3,  // shortened second green and walk, ticks (1..15)
   parameter int T_YEL  = 2   // yellow, ticks (1..15)
) (
   input logic                 clock,
   input logic                 Reset,
   traffic_light_fsm_if.slave  bus
);

   typedef enum logic [2:0] {
      S_MG,
      S_MG2,
      S_MY,
      S_WALK,
      S_SG,
      S_SY
   } state_t;

   typedef struct packed {
      logic main_red;
      logic main_yellow;
      logic main_green;
      logic side_red;
      logic side_yellow;
      logic side_green;
      logic walk;
   } lamps_t;

   // Counter load values are duration-1: a phase ends on the tick that finds 0.
   localparam logic [3:0] L_BASE = 4'(T_BASE - 1);
   localparam logic [3:0] L_EXT  = 4'(T_EXT - 1);
   localparam logic [3:0] L_YEL  = 4'(T_YEL - 1);

   state_t     r_state;
   logic [3:0] r_count;
   lamps_t     r_lamps;
   logic       r_wr_reset;

   logic       w_expire;
   state_t     w_next;
   logic [3:0] w_load;

   // Lamp pattern shown in each state; any unused encoding shows all red.
   function automatic lamps_t decode(state_t s);
      lamps_t l;
      l = '{main_red: 1'b1, side_red: 1'b1, default: 1'b0};
      case (s)
         S_MG, S_MG2: l = '{main_green: 1'b1, side_red: 1'b1, default: 1'b0};
         S_MY:        l = '{main_yellow: 1'b1, side_red: 1'b1, default: 1'b0};
         S_WALK:      l = '{main_red: 1'b1, side_red: 1'b1, walk: 1'b1, default: 1'b0};
         S_SG:        l = '{main_red: 1'b1, side_green: 1'b1, default: 1'b0};
         S_SY:        l = '{main_red: 1'b1, side_yellow: 1'b1, default: 1'b0};
         default:     l = '{main_red: 1'b1, side_red: 1'b1, default: 1'b0};
      endcase
      return l;
   endfunction

   // Successor state and its counter load, used only when the phase expires.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_expire = bus.Tick && (r_count == 4'd0);
      w_next   = S_MG;
      w_load   = L_BASE;
      case (r_state)
         S_MG: begin
            // Sensor is looked at only on this edge; later changes do not shorten MG2 further.
            w_next = S_MG2;
            w_load = bus.Sensor ? L_EXT : L_BASE;
         end
         S_MG2: begin
            w_next = S_MY;
            w_load = L_YEL;
         end
         S_MY: begin
            // A request that arrives after this edge waits for the next main yellow.
            w_next = bus.WR ? S_WALK : S_SG;
            w_load = bus.WR ? L_EXT : L_BASE;
         end
         S_WALK: begin
            w_next = S_SG;
            w_load = L_BASE;
         end
         S_SG: begin
            w_next = S_SY;
            w_load = L_YEL;
         end
         S_SY: begin
            w_next = S_MG;
            w_load = L_BASE;
         end
         default: begin
            w_next = S_MG;
            w_load = L_BASE;
         end
      endcase
   end

   // State, phase counter and registered outputs; Reset wins over Tick.
   always_ff @(posedge clock) begin
      // NOTE: all state here uses <= so every register samples the pre-edge values of the others.
      if (Reset) begin
         r_state    <= S_MG;
         r_count    <= L_BASE;
         r_lamps    <= decode(S_MG);
         r_wr_reset <= 1'b1;
      end else begin
         r_wr_reset <= 1'b0;
         if (w_expire) begin
            r_state    <= w_next;
            r_count    <= w_load;
            r_lamps    <= decode(w_next);
            r_wr_reset <= (w_next == S_WALK);
         end else if (bus.Tick) begin
            r_count <= r_count - 4'd1;
         end
      end
   end

   assign bus.Main_Red    = r_lamps.main_red;
   assign bus.Main_Yellow = r_lamps.main_yellow;
   assign bus.Main_Green  = r_lamps.main_green;
   assign bus.Side_Red    = r_lamps.side_red;
   assign bus.Side_Yellow = r_lamps.side_yellow;
   assign bus.Side_Green  = r_lamps.side_green;
   assign bus.Walk_Lamp   = r_lamps.walk;
   assign bus.WR_Reset    = r_wr_reset;

endmodule

// File: tb/tb_traffic_light_fsm.sv
`timescale 1ns/1ps
// tb_traffic_light_fsm
// Two controllers share Reset, WR and Sensor: dut_a uses default timings with
// a sparse tick, dut_b has every duration set to 1 with Tick held high.
// The driver steps a phase-level model of each controller at every negedge
// and queues the expected lamps/strobe; the monitor compares after each posedge.
module tb_traffic_light_fsm;

   localparam int P_MG   = 0;
   localparam int P_MG2  = 1;
   localparam int P_MY   = 2;
   localparam int P_WALK = 3;
   localparam int P_SG   = 4;
   localparam int P_SY   = 5;

   typedef struct {
      int phase;
      int elapsed;  // ticks already spent in the phase
      int dur;      // ticks the phase lasts, fixed on entry
   } mdl_t;

   logic clock = 1'b0;
   logic rst   = 1'b0;
   always #5 clock = ~clock;

   traffic_light_fsm_if bus_a ();
   traffic_light_fsm_if bus_b ();

   traffic_light_fsm #(.T_BASE(6), .T_EXT(3), .T_YEL(2)) dut_a (
      .clock (clock),
      .Reset (rst),
      .bus   (bus_a)
   );

   traffic_light_fsm #(.T_BASE(1), .T_EXT(1), .T_YEL(1)) dut_b (
      .clock (clock),
      .Reset (rst),
      .bus   (bus_b)
   );

   mdl_t       m_a;
   mdl_t       m_b;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   bit         wr_reg = 1'b0;

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected lamps {MR,MY,MG,SR,SY,SG,Walk} for each phase.
   function automatic logic [6:0] lamps_of(int phase);
      case (phase)
         P_MG, P_MG2: return 7'b001_100_0;
         P_MY:        return 7'b010_100_0;
         P_WALK:      return 7'b100_100_1;
         P_SG:        return 7'b100_001_0;
         default:     return 7'b100_010_0;
      endcase
   endfunction

   function automatic int dur_of(int phase, bit sensor, int tb, int te, int ty);
      case (phase)
         P_MG:    return tb;
         P_MG2:   return sensor ? te : tb;
         P_MY:    return ty;
         P_WALK:  return te;
         P_SG:    return tb;
         default: return ty;
      endcase
   endfunction

   // One clock edge of the controller, described as a ring of phases where
   // the walk phase is skipped unless a request is pending at yellow expiry.
   function automatic mdl_t step(mdl_t m, bit r, bit tick, bit wr, bit sensor,
                                 int tb, int te, int ty, output bit wrr);
      mdl_t n;
      int   nxt;
      n   = m;
      wrr = 1'b0;
      if (r) begin
         n.phase   = P_MG;
         n.elapsed = 0;
         n.dur     = tb;
         wrr       = 1'b1;
      end else if (tick) begin
         n.elapsed = m.elapsed + 1;
         if (n.elapsed >= m.dur) begin
            nxt = (m.phase + 1) % 6;
            if (nxt == P_WALK && !wr) nxt = P_SG;
            n.phase   = nxt;
            n.elapsed = 0;
            n.dur     = dur_of(nxt, sensor, tb, te, ty);
            wrr       = (nxt == P_WALK);
         end
      end
      return n;
   endfunction

   function automatic bit tick4();
      return (cyc % 4) == 3;
   endfunction

   // Apply one clock's worth of inputs and queue what both controllers must show after the edge.
   task automatic drive(bit r, bit tick_a, bit sensor);
      bit wrr_a;
      bit wrr_b;
      @(negedge clock);
      cyc++;
      rst          = r;
      bus_a.Tick   = tick_a;
      bus_a.WR     = wr_reg;
      bus_a.Sensor = sensor;
      bus_b.Tick   = 1'b1;
      bus_b.WR     = wr_reg;
      bus_b.Sensor = sensor;
      m_a = step(m_a, r, tick_a, wr_reg, sensor, 6, 3, 2, wrr_a);
      m_b = step(m_b, r, 1'b1,  wr_reg, sensor, 1, 1, 1, wrr_b);
      q_a.push_back({lamps_of(m_a.phase), wrr_a});
      q_b.push_back({lamps_of(m_b.phase), wrr_b});
      // The walk register is cleared by the controller's strobe.
      if (wrr_a) wr_reg = 1'b0;
   endtask

   // Monitor: one expected entry per controller per clock, plus head sanity.
   initial begin
      logic [7:0] exp_v;
      logic [7:0] act_v;
      forever begin
         @(posedge clock);
         #2;
         if (q_a.size() > 0) begin
            exp_v = q_a.pop_front();
            act_v = {bus_a.Main_Red, bus_a.Main_Yellow, bus_a.Main_Green,
                     bus_a.Side_Red, bus_a.Side_Yellow, bus_a.Side_Green,
                     bus_a.Walk_Lamp, bus_a.WR_Reset};
            check("dut_a outputs", int'(act_v), int'(exp_v));
            check("dut_a main one-hot", $countones(act_v[7:5]), 1);
            check("dut_a side one-hot", $countones(act_v[4:2]), 1);
            check("dut_a two greens", int'(act_v[5] & act_v[2]), 0);
         end
         if (q_b.size() > 0) begin
            exp_v = q_b.pop_front();
            act_v = {bus_b.Main_Red, bus_b.Main_Yellow, bus_b.Main_Green,
                     bus_b.Side_Red, bus_b.Side_Yellow, bus_b.Side_Green,
                     bus_b.Walk_Lamp, bus_b.WR_Reset};
            check("dut_b outputs", int'(act_v), int'(exp_v));
            check("dut_b main one-hot", $countones(act_v[7:5]), 1);
            check("dut_b side one-hot", $countones(act_v[4:2]), 1);
            check("dut_b two greens", int'(act_v[5] & act_v[2]), 0);
         end
      end
   end

   initial begin
      int guard;
      m_a = '{phase: P_MG, elapsed: 0, dur: 6};
      m_b = '{phase: P_MG, elapsed: 0, dur: 1};
      bus_a.Tick = 1'b0; bus_a.WR = 1'b0; bus_a.Sensor = 1'b0;
      bus_b.Tick = 1'b0; bus_b.WR = 1'b0; bus_b.Sensor = 1'b0;

      // Reset, then two full 22-tick cycles with no requests and a tick every 4 clocks.
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2 * 22 * 4 + 8; i++) drive(1'b0, tick4(), 1'b0);

      // Sensor high across MG expiry, then dropped in the middle of MG2.
      guard = 0;
      while (m_a.phase != P_MG && guard < 400) begin drive(1'b0, tick4(), 1'b0); guard++; end
      while (m_a.phase != P_MG2 && guard < 400) begin drive(1'b0, tick4(), 1'b1); guard++; end
      check("reach MG2", int'(m_a.phase == P_MG2), 1);
      for (int i = 0; i < 6; i++) drive(1'b0, tick4(), 1'b1);
      for (int i = 0; i < 60; i++) drive(1'b0, tick4(), 1'b0);

      // Walk request raised during main green: walk phase, single strobe, then side green.
      guard = 0;
      while (m_a.phase != P_MG && guard < 400) begin drive(1'b0, tick4(), 1'b0); guard++; end
      wr_reg = 1'b1;
      while (m_a.phase != P_SG && guard < 400) begin drive(1'b0, tick4(), 1'b0); guard++; end
      check("walk then side green", int'(m_a.phase == P_SG), 1);

      // Request one clock after yellow expiry: waits for the following yellow.
      guard = 0;
      while (m_a.phase != P_MY && guard < 400) begin drive(1'b0, tick4(), 1'b0); guard++; end
      while (m_a.phase == P_MY && guard < 400) begin drive(1'b0, tick4(), 1'b0); guard++; end
      check("late request edge", int'(m_a.phase == P_SG), 1);
      wr_reg = 1'b1;
      for (int i = 0; i < 24 * 4; i++) drive(1'b0, tick4(), 1'b0);

      // Reset in side green with three ticks left on the counter, while Tick is high.
      guard = 0;
      while (!(m_a.phase == P_SG && m_a.elapsed == 2) && guard < 400) begin
         drive(1'b0, tick4(), 1'b0);
         guard++;
      end
      check("reach SG count 3", int'(m_a.phase == P_SG && m_a.elapsed == 2), 1);
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 30 * 4; i++) drive(1'b0, tick4(), 1'b0);

      // Tick withheld: everything frozen.
      for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, $urandom_range(0, 1) == 1);

      // Random traffic: sparse ticks, noisy sensor, occasional requests and resets.
      for (int i = 0; i < 1500; i++) begin
         if (!wr_reg && $urandom_range(0, 19) == 0) wr_reg = 1'b1;
         drive($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 1) == 1);
      end

      repeat (3) @(posedge clock);
      #3;
      check("queue a drained", q_a.size(), 0);
      check("queue b drained", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
